// File: rtl/mmio_bridge.sv
// Data-memory port bridge: RAM pass-through plus an MMIO window of
// per-channel command FIFOs and status registers.
module mmio_bridge #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 12'hF00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        address_dmem,
  input  logic [DATA_W-1:0]        data,
  input  logic                     wren,
  output logic [DATA_W-1:0]        q_dmem,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_data,
  output logic                     mem_wren,
  input  logic [DATA_W-1:0]        mem_q,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH-1:0]        ch_overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] P_LO = {1'b0, MMIO_BASE};
  localparam logic [ADDR_W:0] P_HI =
    P_LO + (ADDR_W+1)'(2*NUM_CH);

  logic                     w_hit;
  logic [ADDR_W-1:0]        w_off;
  logic [NUM_CH-1:0]        w_sel;
  logic [NUM_CH-1:0]        w_push;
  logic [NUM_CH-1:0]        w_clr;
  logic [NUM_CH*DATA_W-1:0] w_stat;
  logic [DATA_W-1:0]        w_rd;

  assign w_hit = ({1'b0, address_dmem} >= P_LO) &&
                 ({1'b0, address_dmem} <  P_HI);
  assign w_off = address_dmem - MMIO_BASE;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;
    logic [PW:0]       r_cnt;
    logic              r_ovf;
    logic              w_full;
    logic              w_pop;
    logic              w_acc;

    assign w_sel[c]  = w_hit &&
      (w_off[ADDR_W-1:1] == (ADDR_W-1)'(c));
    assign w_push[c] = wren & w_sel[c] & ~w_off[0];
    assign w_clr[c]  = wren & w_sel[c] &  w_off[0];

    assign w_full = (r_cnt == (PW+1)'(FIFO_DEPTH));
    assign w_pop  = (r_cnt != '0) & ch_ready[c];
    // A pop on the same edge frees the slot a full push needs
    assign w_acc  = w_push[c] & (~w_full | w_pop);

    always_ff @(posedge clock) begin
      if (w_acc) r_mem[r_wp] <= data;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_pop) r_rp <= r_rp + 1'b1;
        if (w_acc) r_wp <= r_wp + 1'b1;
        if (w_acc & ~w_pop)
          r_cnt <= r_cnt + 1'b1;
        else if (~w_acc & w_pop)
          r_cnt <= r_cnt - 1'b1;
        if (w_push[c] & ~w_acc)
          r_ovf <= 1'b1;
        else if (w_clr[c])
          r_ovf <= 1'b0;
      end
    end

    assign ch_valid[c]    = (r_cnt != '0);
    assign ch_overflow[c] = r_ovf;
    assign ch_data[c*DATA_W +: DATA_W] =
      ch_valid[c] ? r_mem[r_rp] : '0;
    assign w_stat[c*DATA_W +: DATA_W] =
      DATA_W'({r_ovf, 22'b0, w_full, 8'(r_cnt)});
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel[i] && w_off[0])
        w_rd = w_stat[i*DATA_W +: DATA_W];
    end
  end

  assign mem_address = address_dmem;
  assign mem_data    = data;
  assign mem_wren    = wren & ~w_hit;
  assign q_dmem      = w_hit ? w_rd : mem_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge: pass-through, FIFO order,
// overflow, full push+pop and reset mid-drain.
module tb_mmio_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;
  logic [1:0]  ch_valid;
  logic [63:0] ch_data;
  logic [1:0]  ch_ready;
  logic [1:0]  ch_overflow;

  logic [31:0] ram [4096];
  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  always @(posedge clock)
    if (mem_wren) ram[mem_address] <= mem_data;
  assign mem_q = ram[mem_address];

  mmio_bridge dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .mem_q        (mem_q),
    .ch_valid     (ch_valid),
    .ch_data      (ch_data),
    .ch_ready     (ch_ready),
    .ch_overflow  (ch_overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [11:0] a,
                    input logic [31:0] d);
    address_dmem = a;
    data         = d;
    wren         = 1'b1;
    tick();
    wren         = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [11:0] a,
                    input logic [31:0] exp);
    address_dmem = a;
    wren         = 1'b0;
    #1;
    chk(tag, q_dmem, exp);
  endtask

  initial begin
    reset        = 1'b1;
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    ch_ready     = '0;
    tick();
    tick();

    // reset state
    chk("rst_valid", 32'(ch_valid), 32'h0);
    chk("rst_ovf", 32'(ch_overflow), 32'h0);
    chk("rst_data0", ch_data[31:0], 32'h0);
    rd("rst_stat0", 12'hF01, 32'h0);
    reset = 1'b0;
    tick();

    // RAM pass-through
    address_dmem = 12'h010;
    data         = 32'hDEAD;
    wren         = 1'b1;
    #1;
    chk("pt_wren", 32'(mem_wren), 32'h1);
    chk("pt_addr", 32'(mem_address), 32'h010);
    chk("pt_wdata", mem_data, 32'hDEAD);
    tick();
    wren = 1'b0;
    rd("pt_q", 12'h010, 32'hDEAD);
    chk("pt_memq", mem_q, 32'hDEAD);
    address_dmem = 12'hF00;
    wren         = 1'b1;
    #1;
    chk("pt_win_wren", 32'(mem_wren), 32'h0);
    wren = 1'b0;
    #1;

    // FIFO order on ch0, no fall-through
    address_dmem = 12'hF00;
    data         = 32'd1;
    wren         = 1'b1;
    #1;
    chk("no_fall", 32'(ch_valid), 32'h0);
    tick();
    wren = 1'b0;
    wr(12'hF00, 32'd2);
    wr(12'hF00, 32'd3);
    rd("ord_stat", 12'hF01, 32'h3);
    rd("cmd_rd", 12'hF00, 32'h0);
    chk("ord_valid", 32'(ch_valid), 32'h1);
    ch_ready = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk($sformatf("ord_d%0d", i), ch_data[31:0],
          32'(i));
      tick();
    end
    chk("ord_empty", 32'(ch_valid), 32'h0);
    ch_ready = 2'b00;
    rd("ord_stat0", 12'hF01, 32'h0);

    // overflow on ch1
    for (int i = 1; i <= 5; i++) wr(12'hF02, 32'(i));
    rd("ovf_stat", 12'hF03, 32'h8000_0104);
    chk("ovf_flag", 32'(ch_overflow), 32'h2);
    rd("ovf_ch0", 12'hF01, 32'h0);
    wr(12'hF03, 32'h1234);
    rd("ovf_clr", 12'hF03, 32'h0000_0104);
    chk("ovf_flag0", 32'(ch_overflow), 32'h0);
    ch_ready = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk($sformatf("ovf_d%0d", i), ch_data[63:32],
          32'(i));
      tick();
    end
    chk("ovf_empty", 32'(ch_valid), 32'h0);
    ch_ready = 2'b00;

    // full push + pop on ch0
    for (int i = 0; i < 4; i++)
      wr(12'hF00, 32'h10 + 32'(i));
    rd("full_stat", 12'hF01, 32'h0000_0104);
    ch_ready = 2'b01;
    wr(12'hF00, 32'h55);
    ch_ready = 2'b00;
    rd("fpp_stat", 12'hF01, 32'h0000_0104);
    chk("fpp_ovf", 32'(ch_overflow), 32'h0);
    ch_ready = 2'b01;
    #1;
    chk("fpp_d0", ch_data[31:0], 32'h11);
    tick();
    chk("fpp_d1", ch_data[31:0], 32'h12);
    tick();
    chk("fpp_d2", ch_data[31:0], 32'h13);
    tick();
    chk("fpp_d3", ch_data[31:0], 32'h55);
    tick();
    chk("fpp_empty", 32'(ch_valid), 32'h0);
    ch_ready = 2'b00;

    // reset mid-drain
    for (int i = 0; i < 3; i++)
      wr(12'hF00, 32'hA0 + 32'(i));
    chk("mid_valid", 32'(ch_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(ch_valid), 32'h0);
    tick();
    reset = 1'b0;
    rd("mid_stat", 12'hF01, 32'h0);
    chk("mid_data", ch_data[31:0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
